riscv_alu_seq: RTL and testbench
================================

# riscv_alu_seq

Parametrised, handshaked successor to the 8-bit ALU-plus-control top. It decodes the RISC-V `aluop`/`funcCode` pair internally, executes WIDTH-bit operations, and returns a registered result with zero/carry/overflow flags. Shifts, and optionally multiply, run iteratively over several cycles. The block sits between the decode stage and writeback behind a valid/ready handshake on both sides.

## Interface
- `WIDTH`, 8: operand and result width. Must be a power of two, ≥ 4. `SHW = $clog2(WIDTH)`.
- `clk` in 1: clock. Rising edge active.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `aluop` in 2: 00 = ADD, 01 = SUB, 10 = R-type (decode `funcCode`), 11 = reserved.
- `funcCode` in 10: `{funct7, funct3}`.
- `a`, `b` in WIDTH: operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out WIDTH: operation result.
- `zero` out 1: `result == 0`.
- `carryout` out 1: carry out of ADD/SUB. 0 for all other ops.
- `overflow` out 1: signed overflow of ADD/SUB. 0 for all other ops.
- `err` out 1: request was illegal or reserved.

## Operation
- R-type decode (funct7_funct3):
  - 0000000_000 ADD; 0100000_000 SUB
  - 0000000_111 AND; 0000000_110 OR; 0000000_100 XOR
  - 0000000_010 SLT (signed); 0000000_011 SLTU
  - 0000000_001 SLL; 0000000_101 SRL; 0100000_101 SRA
  - 0000001_000 MUL, only when the macro is defined
  - Anything else is illegal.
- SUB is computed as `a + ~b + 1`. `carryout` = bit WIDTH of that sum, so 1 means no borrow.
- `overflow` = (sign a == sign of second addend) && (sign result != sign a).
- SLT/SLTU produce 0 or 1, zero-extended.
- Shift amount = `b[SHW-1:0]`. Upper bits of `b` are ignored.
- Illegal request or `aluop = 11`: `result = 0`, `zero = 1`, `err = 1`, other flags 0.
- FSM states:
  - **IDLE**: `in_ready = 1`. On accept:
    - single-cycle op → DONE
    - shift with amount 0 → DONE
    - shift with amount n > 0 → SHIFT, counter = n
    - MUL → MUL, counter = WIDTH
  - **SHIFT**: shift the working register by 1 each cycle (SRA replicates the MSB). Decrement the counter; at 1 → DONE.
  - **MUL**: shift-add, one multiplier bit per cycle, WIDTH cycles → DONE. Result is the low WIDTH bits of the product.
  - **DONE**: `out_valid = 1`. On `out_ready` → IDLE.
- `in_ready` is 1 only in IDLE. No new request is accepted while DONE, even if `out_ready` is high.
- `result`, flags and `err` are registered. They stay stable throughout DONE and hold their value after the handshake until the next completion.

## Timing
- Reset (asynchronous assert): state = IDLE, `in_ready = 1`, `out_valid = 0`, `result = 0`, `zero = 0`, `carryout = 0`, `overflow = 0`, `err = 0`.
- Reset mid-SHIFT, mid-MUL or in DONE aborts the operation; no result is ever presented. Release is synchronous to the next edge.
- Latency is counted from the accept edge to the first edge at which `out_valid` is sampled high:
  - single-cycle op, zero-amount shift, illegal request: 1
  - shift by n: n + 1
  - MUL: WIDTH + 1
- Backpressure: DONE persists indefinitely while `out_ready = 0`. Outputs hold and `in_ready` stays 0.
- Maximum throughput is one request per 2 cycles. Operands are captured at accept, so `a`/`b` may change afterwards.
- `out_ready` sampled high outside DONE has no effect.

## Configuration
- `RISCV_ALU_MUL_EN` defined: MUL is decoded and takes WIDTH + 1 cycles. `carryout` and `overflow` are 0 for MUL.
- `RISCV_ALU_MUL_EN` undefined: 0000001_000 is illegal and returns `err = 1` after 1 cycle. No multiplier state or datapath is synthesised.

## Test plan
- WIDTH = 8, `aluop = 00`, `a = 0x7F`, `b = 0x01` → `out_valid` 1 cycle after accept, `result = 0x80`, `overflow = 1`, `carryout = 0`, `zero = 0`.
- `aluop = 01`, `a = b = 0x05` → `result = 0x00`, `zero = 1`, `carryout = 1`, `overflow = 0`.
- SRA (0100000_101), `a = 0x80`, `b = 0x0B` (amount 3) → `result = 0xF0`, latency 4, `in_ready = 0` for those 4 cycles.
- SLL by 2 with `out_ready` held low 5 cycles after `out_valid` → `result` and flags stable, `in_ready = 0`. A request presented during DONE is not accepted; it is accepted on the cycle after the handshake.
- Drop `rst_n` during cycle 2 of an SRL by 5 → immediate `out_valid = 0`, `result = 0`, `in_ready = 1`. The next ADD 0x03 + 0x04 completes normally with `0x07`.
- MUL `0x0D × 0x0B`: with `RISCV_ALU_MUL_EN` → `result = 0x8F`, latency 9. Without it → `err = 1`, `result = 0`, latency 1. `aluop = 11` → `err = 1` in both builds.

Source files
------------

// File: rtl/riscv_alu_seq.sv
// riscv_alu_seq: handshaked RISC-V ALU with internal aluop/funcCode decode.
// Single-cycle ops finish in one cycle; shifts iterate one bit per cycle and,
// when the RISCV_ALU_MUL_EN macro is defined, MUL runs a WIDTH-cycle shift-add.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake (accepted only in IDLE)
//   aluop, funcCode      operation select ({funct7, funct3} for R-type)
//   a, b                 WIDTH-bit operands, captured at accept
//   out_valid/out_ready  result handshake (held in DONE until out_ready)
//   result, zero, carryout, overflow, err   registered result and flags
module riscv_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [9:0]       funcCode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carryout,
  output logic             overflow,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_e;

  state_e           state, state_nxt;
  logic             in_ready_nxt, out_valid_nxt;
  op_e              op, shop;
  logic [SHW-1:0]   amt;
  logic             is_shift;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] work, shift_nxt;
  logic [WIDTH-1:0] addend, alu_res;
  logic [WIDTH:0]   sum;
  logic             alu_c, alu_v, alu_err;

`ifdef RISCV_ALU_MUL_EN
  logic [WIDTH-1:0] acc, mcand, mplier, mul_nxt;
`endif

  // Decode aluop / funcCode into an internal operation
  always_comb begin
    op = OP_ILL;
    case (aluop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (funcCode)
          10'b0000000_000: op = OP_ADD;
          10'b0100000_000: op = OP_SUB;
          10'b0000000_111: op = OP_AND;
          10'b0000000_110: op = OP_OR;
          10'b0000000_100: op = OP_XOR;
          10'b0000000_010: op = OP_SLT;
          10'b0000000_011: op = OP_SLTU;
          10'b0000000_001: op = OP_SLL;
          10'b0000000_101: op = OP_SRL;
          10'b0100000_101: op = OP_SRA;
`ifdef RISCV_ALU_MUL_EN
          10'b0000001_000: op = OP_MUL;
`endif
          default:         op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  assign amt      = b[SHW-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  // Single-cycle datapath; SUB is a + ~b + 1 so carryout=1 means no borrow
  always_comb begin
    addend  = (op == OP_SUB) ? ~b : b;
    sum     = {1'b0, a} + {1'b0, addend} + (WIDTH+1)'(op == OP_SUB);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_res = WIDTH'(a < b);
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;  // only reached with amount 0
      default: alu_err = 1'b1;
    endcase
  end

  // One-bit shift step; SRA replicates the MSB
  always_comb begin
    case (shop)
      OP_SLL:  shift_nxt = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_nxt = {1'b0, work[WIDTH-1:1]};
      default: shift_nxt = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

`ifdef RISCV_ALU_MUL_EN
  assign mul_nxt = acc + (mplier[0] ? mcand : '0);
`endif

  // State register with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift && (amt != '0)) state_nxt = S_SHIFT;
`ifdef RISCV_ALU_MUL_EN
          else if (op == OP_MUL)       state_nxt = S_MUL;
`endif
          else                         state_nxt = S_DONE;
        end
      end
      S_SHIFT: if (cnt == CW'(1)) state_nxt = S_DONE;
`ifdef RISCV_ALU_MUL_EN
      S_MUL:   if (cnt == CW'(1)) state_nxt = S_DONE;
`endif
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state
  always_comb begin
    in_ready_nxt  = (state_nxt == S_IDLE);
    out_valid_nxt = (state_nxt == S_DONE);
  end

  // Operand capture, iteration and result commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      cnt      <= '0;
      shop     <= OP_ADD;
      result   <= '0;
      zero     <= 1'b0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
`ifdef RISCV_ALU_MUL_EN
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work <= a;
            shop <= op;
            cnt  <= CW'(amt);
            if (state_nxt == S_DONE) begin
              result   <= alu_res;
              zero     <= (alu_res == '0);
              carryout <= alu_c;
              overflow <= alu_v;
              err      <= alu_err;
            end
`ifdef RISCV_ALU_MUL_EN
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
              cnt    <= CW'(WIDTH);
            end
`endif
          end
        end
        S_SHIFT: begin
          work <= shift_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result   <= shift_nxt;
            zero     <= (shift_nxt == '0);
            carryout <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
          end
        end
`ifdef RISCV_ALU_MUL_EN
        S_MUL: begin
          acc    <= mul_nxt;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result   <= mul_nxt;
            zero     <= (mul_nxt == '0);
            carryout <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_alu_seq.sv
// Testbench for riscv_alu_seq (WIDTH = 8): directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model. Honours RISCV_ALU_MUL_EN like the design.
module tb_riscv_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [1:0] aluop;
  logic [9:0] funccode;
  logic [7:0] a, b;
  logic       out_valid, out_ready;
  logic [7:0] result;
  logic       zero, carryout, overflow, err;

  int n_checks = 0;
  int n_pass   = 0;

  riscv_alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funcCode(funccode), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carryout(carryout),
    .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: outcome of one request computed with plain integer arithmetic
  function automatic void ref_op(input logic [1:0] op, input logic [9:0] fc,
                                 input logic [7:0] ia, input logic [7:0] ib,
                                 output logic [7:0] r, output logic c,
                                 output logic v, output logic e, output int lat);
    int ua, ub, sa, sb, s, amt, k;
    ua = int'(ia); ub = int'(ib);
    sa = int'($signed(ia)); sb = int'($signed(ib));
    amt = ub % 8;
    r = 8'h00; c = 1'b0; v = 1'b0; e = 1'b0; lat = 1;
    if (op == 2'd0) k = 0;
    else if (op == 2'd1) k = 1;
    else if (op == 2'd3) k = 99;
    else begin
      case (fc)
        10'b0000000000: k = 0;
        10'b0100000000: k = 1;
        10'b0000000111: k = 2;
        10'b0000000110: k = 3;
        10'b0000000100: k = 4;
        10'b0000000010: k = 5;
        10'b0000000011: k = 6;
        10'b0000000001: k = 7;
        10'b0000000101: k = 8;
        10'b0100000101: k = 9;
        10'b0000001000: k = 10;
        default:        k = 99;
      endcase
    end
    case (k)
      0:  begin r = 8'(ua + ub); c = (ua + ub) > 255; s = sa + sb; v = (s > 127) || (s < -128); end
      1:  begin r = 8'(ua - ub); c = (ua >= ub);      s = sa - sb; v = (s > 127) || (s < -128); end
      2:  r = ia & ib;
      3:  r = ia | ib;
      4:  r = ia ^ ib;
      5:  r = (sa < sb) ? 8'h01 : 8'h00;
      6:  r = (ua < ub) ? 8'h01 : 8'h00;
      7:  begin r = 8'(ua << amt);  lat = amt + 1; end
      8:  begin r = 8'(ua >> amt);  lat = amt + 1; end
      9:  begin r = 8'(sa >>> amt); lat = amt + 1; end
`ifdef RISCV_ALU_MUL_EN
      10: begin r = 8'(ua * ub); lat = 9; end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  // Transaction-level model: 0 = idle, 1 = busy, 2 = result presented
  int         m_state, m_left, p_lat;
  logic [7:0] p_r, m_r;
  logic       p_c, p_v, p_e, m_z, m_c, m_v, m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_left = 0;
      m_r = 8'h00; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0; m_e = 1'b0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          ref_op(aluop, funccode, a, b, p_r, p_c, p_v, p_e, p_lat);
          m_left  = p_lat - 1;
          m_state = 1;
        end
        2: if (out_ready) m_state = 0;
        default: m_left--;
      endcase
      if (m_state == 1 && m_left == 0) begin
        m_r = p_r; m_z = (p_r == 8'h00); m_c = p_c; m_v = p_v; m_e = p_e;
        m_state = 2;
      end
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    check("in_ready",  32'(in_ready),  32'(m_state == 0));
    check("out_valid", 32'(out_valid), 32'(m_state == 2));
    check("result",    32'(result),    32'(m_r));
    check("zero",      32'(zero),      32'(m_z));
    check("carryout",  32'(carryout),  32'(m_c));
    check("overflow",  32'(overflow),  32'(m_v));
    check("err",       32'(err),       32'(m_e));
  end

  // Issue one request, report latency, optionally keep a next request pending
  task automatic txn(input logic [1:0] op, input logic [9:0] fc,
                     input logic [7:0] ta, input logic [7:0] tb_v,
                     input int hold, input bit pend, output int lat);
    int n;
    @(negedge clk);
    aluop = op; funccode = fc; a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    if (pend) begin aluop = 2'b00; a = 8'h10; b = 8'h20; end
    else begin in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("done_timeout", 32'(lat < 100), 32'd1);
    repeat (hold) @(negedge clk);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  logic [9:0] codes [11] = '{10'b0000000000, 10'b0100000000, 10'b0000000111,
                             10'b0000000110, 10'b0000000100, 10'b0000000010,
                             10'b0000000011, 10'b0000000001, 10'b0000000101,
                             10'b0100000101, 10'b0000001000};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] rr;
    logic rc, rv, re;
    int rl;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    aluop = 2'b00; funccode = 10'h0; a = 8'h00; b = 8'h00;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({zero, carryout, overflow, err}), 32'd0);
    rst_n = 1'b1;

    // Pin the model with hand-computed values
    ref_op(2'b00, 10'h0, 8'h7F, 8'h01, rr, rc, rv, re, rl);
    check("model_add", 32'({rr, rc, rv, re}), 32'({8'h80, 1'b0, 1'b1, 1'b0}));
    ref_op(2'b10, 10'b0100000101, 8'h80, 8'h0B, rr, rc, rv, re, rl);
    check("model_sra", 32'({rr, 8'(rl)}), 32'({8'hF0, 8'd4}));
    ref_op(2'b10, 10'b0000000010, 8'hFF, 8'h01, rr, rc, rv, re, rl);
    check("model_slt", 32'(rr), 32'h01);

    // ADD overflow
    txn(2'b00, 10'h0, 8'h7F, 8'h01, 0, 1'b0, lat);
    check("add_lat", 32'(lat), 32'd1);
    check("add_res", 32'({result, zero, carryout, overflow, err}), 32'({8'h80, 4'b0010}));
    // SUB equal operands
    txn(2'b01, 10'h3FF, 8'h05, 8'h05, 0, 1'b0, lat);
    check("sub_res", 32'({result, zero, carryout, overflow, err}), 32'({8'h00, 4'b1100}));
    // SRA by 3 (upper bits of b ignored)
    txn(2'b10, 10'b0100000101, 8'h80, 8'h0B, 0, 1'b0, lat);
    check("sra_lat", 32'(lat), 32'd4);
    check("sra_res", 32'(result), 32'hF0);
    // SLL by 2 with backpressure and a request waiting during DONE
    txn(2'b10, 10'b0000000001, 8'h35, 8'h02, 5, 1'b1, lat);
    check("sll_lat", 32'(lat), 32'd3);
    check("sll_res", 32'(result), 32'hD4);
    check("pend_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pend_done", 32'({out_valid, result}), 32'({1'b1, 8'h30}));
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;

    // Reset in the middle of an SRL by 5
    @(negedge clk);
    aluop = 2'b10; funccode = 10'b0000000101; a = 8'hA5; b = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2; rst_n = 1'b0; #1;
    check("mid_rst", 32'({out_valid, in_ready, result}), 32'({1'b0, 1'b1, 8'h00}));
    @(negedge clk); rst_n = 1'b1;
    txn(2'b00, 10'h0, 8'h03, 8'h04, 0, 1'b0, lat);
    check("post_rst_add", 32'({result, err}), 32'({8'h07, 1'b0}));

    // MUL and reserved aluop
    txn(2'b10, 10'b0000001000, 8'h0D, 8'h0B, 0, 1'b0, lat);
`ifdef RISCV_ALU_MUL_EN
    check("mul", 32'({result, err, 8'(lat)}), 32'({8'h8F, 1'b0, 8'd9}));
`else
    check("mul", 32'({result, err, 8'(lat)}), 32'({8'h00, 1'b1, 8'd1}));
`endif
    txn(2'b11, 10'h0, 8'h12, 8'h34, 0, 1'b0, lat);
    check("reserved", 32'({result, zero, err, 8'(lat)}), 32'({8'h00, 1'b1, 1'b1, 8'd1}));

    // Randomized traffic, checked by the per-cycle compare against the model
    for (int i = 0; i < 3000; i++) begin
      int sel, ci;
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
      end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      aluop = (sel < 2) ? 2'b00 : (sel < 4) ? 2'b01 : (sel == 4) ? 2'b11 : 2'b10;
      ci = $urandom_range(0, 11);
      funccode = (ci == 11) ? 10'($urandom) : codes[ci];
      a = 8'($urandom);
      b = 8'($urandom);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
